// File: rtl/search_pkg.sv
// search_pkg: state encoding and default sizes shared by addr_range_search and its counter
package search_pkg;
    localparam int A_W     = 8;
    localparam int D_W     = 8;
    localparam int R_DEPTH = 256;
    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_SCAN, S_DRAIN, S_DONE} state_t;
endpackage

// File: rtl/scan_addr_counter.sv
// scan_addr_counter: loadable A-bit address counter with enable and a last flag (cnt==end)
//  clk, rst_n          clock, asynchronous active-low reset
//  i_load, i_load_val  load the window start address (has priority over i_en)
//  i_en                advance by one
//  i_end               window end address
//  o_cnt, o_last       current address, high when the current address is the window end
module scan_addr_counter
    import search_pkg::*;
#(
    parameter int A = A_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [A-1:0] i_load_val,
    input  logic         i_en,
    input  logic [A-1:0] i_end,
    output logic [A-1:0] o_cnt,
    output logic         o_last
);
    logic [A-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)      r_cnt <= '0;
        else if (i_load) r_cnt <= i_load_val;
        else if (i_en)   r_cnt <= r_cnt + A'(1);

    assign o_cnt  = r_cnt;
    assign o_last = r_cnt == i_end;
endmodule

// File: rtl/addr_range_search.sv
// addr_range_search: scans memory window [start_adr..end_adr] for a key, reports first hit
//  clk, reset (async active-low); start/start_adr/end_adr/same/key request inputs
//  mem_rd/mem_adr/mem_rdata shared memory read port (data one cycle after strobe)
//  busy, done, found, match_adr, err result outputs
//  MATCH_COUNT_EN: sweep the whole window and report match_cnt instead of stopping at first hit
module addr_range_search
    import search_pkg::*;
#(
    parameter int A = A_W,
    parameter int D = D_W,
    parameter int R = R_DEPTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [A-1:0] start_adr,
    input  logic [A-1:0] end_adr,
    input  logic         same,
    input  logic [D-1:0] key,
    output logic         mem_rd,
    output logic [A-1:0] mem_adr,
    input  logic [D-1:0] mem_rdata,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic [A-1:0] match_adr,
    output logic         err
`ifdef MATCH_COUNT_EN
    ,
    output logic [A:0]   match_cnt
`endif
);
    if (R != (1 << A)) begin : g_r_chk
        $error("R must equal 2**A");
    end

    state_t       r_state, w_next;
    logic [A-1:0] r_start, r_end, r_adr_d;
    logic [D-1:0] r_key;
    logic         r_same, r_vld;
    logic         w_load, w_en, w_last, w_end_hit, w_hit, w_stop;

    scan_addr_counter #(.A(A)) u_cnt (
        .clk        (clk),
        .rst_n      (reset),
        .i_load     (w_load),
        .i_load_val (r_start),
        .i_en       (w_en),
        .i_end      (r_end),
        .o_cnt      (mem_adr),
        .o_last     (w_last)
    );

    // same=1 forces a single read regardless of the counter compare
    assign w_end_hit = w_last | r_same;
    // only words read in SCAN/DRAIN are compared; the read in flight when leaving on a hit is dropped
    assign w_hit = r_vld && (mem_rdata == r_key) && (r_state == S_SCAN || r_state == S_DRAIN);
`ifdef MATCH_COUNT_EN
    assign w_stop = 1'b0;
`else
    assign w_stop = w_hit;
`endif

    always_comb begin
        w_next = r_state;
        mem_rd = 1'b0;
        w_load = 1'b0;
        w_en   = 1'b0;
        busy   = r_state != S_IDLE;
        done   = r_state == S_DONE;
        case (r_state)
            S_IDLE:  w_next = start ? S_CHECK : S_IDLE;
            S_CHECK: begin
                w_load = 1'b1;
                w_next = (r_start > r_end) ? S_DONE : S_SCAN;
            end
            S_SCAN:  begin
                mem_rd = 1'b1;
                w_en   = !w_end_hit;
                w_next = w_stop ? S_DONE : w_end_hit ? S_DRAIN : S_SCAN;
            end
            S_DRAIN: w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_state   <= S_IDLE;
            r_start   <= '0;
            r_end     <= '0;
            r_key     <= '0;
            r_same    <= 1'b0;
            r_vld     <= 1'b0;
            r_adr_d   <= '0;
            found     <= 1'b0;
            match_adr <= '0;
            err       <= 1'b0;
`ifdef MATCH_COUNT_EN
            match_cnt <= '0;
`endif
        end else begin
            r_state <= w_next;
            r_vld   <= mem_rd;
            r_adr_d <= mem_adr;
            if (r_state == S_IDLE && start) begin
                r_start <= start_adr;
                r_end   <= end_adr;
                r_same  <= same;
                r_key   <= key;
                found   <= 1'b0;
                err     <= 1'b0;
`ifdef MATCH_COUNT_EN
                match_cnt <= '0;
`endif
            end
            if (r_state == S_CHECK) err <= r_start > r_end;
            if (w_hit && !found) begin
                found     <= 1'b1;
                match_adr <= r_adr_d;
            end
`ifdef MATCH_COUNT_EN
            if (w_hit && !(&match_cnt)) match_cnt <= match_cnt + (A+1)'(1);
`endif
        end
endmodule
